// File: rtl/id_stage_pipelined_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipelined_if
// Bundles every signal of the decode stage except clk/rst.
//   IF/ID side : in_valid, Instruction, PC_in
//   WB side    : Result_WB, writeBackEn, Dest_wb
//   Hazard unit: hazard, freeze, flush, SR
//   Early decode (combinational): src1, src2, Two_src
//   ID/EX register (registered): out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S,
//     EXE_CMD, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, PC_out
// The slave modport is the decode stage; master is the surrounding pipeline.
// ---------------------------------------------------------------------------
interface id_stage_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic [31:0]       Instruction;
    logic [PC_W-1:0]   PC_in;
    logic [DATA_W-1:0] Result_WB;
    logic              writeBackEn;
    logic [3:0]        Dest_wb;
    logic              hazard;
    logic              freeze;
    logic              flush;
    logic [3:0]        SR;

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              Two_src;

    logic              out_valid;
    logic              WB_EN;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic              B;
    logic              S;
    logic [3:0]        EXE_CMD;
    logic [DATA_W-1:0] Val_Rn;
    logic [DATA_W-1:0] Val_Rm;
    logic              imm;
    logic [11:0]       Shift_operand;
    logic [23:0]       Signed_imm_24;
    logic [3:0]        Dest;
    logic [PC_W-1:0]   PC_out;

    modport master (
        output in_valid, Instruction, PC_in, Result_WB, writeBackEn, Dest_wb,
               hazard, freeze, flush, SR,
        input  src1, src2, Two_src, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S,
               EXE_CMD, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
               Dest, PC_out
    );

    modport slave (
        input  in_valid, Instruction, PC_in, Result_WB, writeBackEn, Dest_wb,
               hazard, freeze, flush, SR,
        output src1, src2, Two_src, out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S,
               EXE_CMD, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24,
               Dest, PC_out
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// ---------------------------------------------------------------------------
// id_stage_pipelined
// ARM-subset decode stage with register file and ID/EX pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-low (clears ID/EX, reloads reg[i] = i)
//   bus  - id_stage_pipelined_if.slave, see interface header for signals
// ID/EX update priority per edge: reset > flush > freeze > normal load.
// ---------------------------------------------------------------------------
module id_stage_pipelined #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int PC_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_pipelined_if.slave  bus
);

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
        logic [PC_W-1:0]   pc;
    } data_t;

    // SR packs flags as {Z,C,V,N}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
        logic z, c, v, n;
        z = sr[3];
        c = sr[2];
        v = sr[1];
        n = sr[0];
        case (cond)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = c;
            4'b0011: cond_check = ~c;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = c & ~z;
            4'b1001: cond_check = ~c | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;   // 1111 never executes
        endcase
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    ctrl_t             ctrl_q, ctrl_d, dec;
    data_t             data_q, data_d, data_new;
    logic              out_valid_q, out_valid_d;

    logic [31:0]       instr;
    logic [1:0]        mode;
    logic              mem_w_dec;
    logic [3:0]        src1, src2;
    logic [DATA_W-1:0] rd_rn, rd_rm;
    logic              kill;

    assign instr     = bus.Instruction;
    assign mode      = instr[27:26];
    assign mem_w_dec = (mode == 2'b01) && !instr[20];
    assign src1      = instr[19:16];
    // Stores read Rd as the data operand instead of Rm
    assign src2      = mem_w_dec ? instr[15:12] : instr[3:0];
    assign kill      = ~bus.in_valid | bus.hazard | ~cond_check(instr[31:28], bus.SR);

    always_comb begin
        dec = '0;
        case (mode)
            2'b00: begin
                dec.s     = instr[20];
                dec.wb_en = 1'b1;
                case (instr[24:21])
                    4'b1101: dec.exe_cmd = 4'b0001;
                    4'b1111: dec.exe_cmd = 4'b1001;
                    4'b0100: dec.exe_cmd = 4'b0010;
                    4'b0101: dec.exe_cmd = 4'b0011;
                    4'b0010: dec.exe_cmd = 4'b0100;
                    4'b0110: dec.exe_cmd = 4'b0101;
                    4'b0000: dec.exe_cmd = 4'b0110;
                    4'b1100: dec.exe_cmd = 4'b0111;
                    4'b0001: dec.exe_cmd = 4'b1000;
                    4'b1010: begin dec.exe_cmd = 4'b0100; dec.wb_en = 1'b0; end
                    4'b1000: begin dec.exe_cmd = 4'b0110; dec.wb_en = 1'b0; end
                    default: dec = '0;
                endcase
            end
            2'b01: begin
                dec.exe_cmd = 4'b0010;
                if (instr[20]) begin
                    dec.mem_r_en = 1'b1;
                    dec.wb_en    = 1'b1;
                end else begin
                    dec.mem_w_en = 1'b1;
                end
            end
            2'b10:   dec.b = 1'b1;
            default: dec = '0;
        endcase
    end

    // Register file reads; WB write-through makes same-cycle writes visible
    always_comb begin
        rd_rn = '0;
        rd_rm = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src1 == 4'(i)) rd_rn = regs_q[i];
            if (src2 == 4'(i)) rd_rm = regs_q[i];
        end
        if (bus.writeBackEn && bus.Dest_wb == src1 && int'(src1) < NUM_REGS) rd_rn = bus.Result_WB;
        if (bus.writeBackEn && bus.Dest_wb == src2 && int'(src2) < NUM_REGS) rd_rm = bus.Result_WB;
    end

    // Writeback is independent of freeze/hazard/flush
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.writeBackEn && bus.Dest_wb == 4'(i)) regs_d[i] = bus.Result_WB;
        end
    end

    always_comb begin
        data_new.val_rn        = rd_rn;
        data_new.val_rm        = rd_rm;
        data_new.imm           = instr[25];
        data_new.shift_operand = instr[11:0];
        data_new.signed_imm_24 = instr[23:0];
        data_new.dest          = instr[15:12];
        data_new.pc            = bus.PC_in;

        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        if (bus.flush) begin
            // Flush beats freeze; data still loads since EXE ignores it
            out_valid_d = 1'b0;
            ctrl_d      = '0;
            data_d      = data_new;
        end else if (!bus.freeze) begin
            out_valid_d = ~kill;
            ctrl_d      = kill ? '0 : dec;
            data_d      = data_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
        end else begin
            regs_q      <= regs_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
        end
    end

    assign bus.src1          = src1;
    assign bus.src2          = src2;
    assign bus.Two_src       = ~instr[25] | mem_w_dec;
    assign bus.out_valid     = out_valid_q;
    assign bus.WB_EN         = ctrl_q.wb_en;
    assign bus.MEM_R_EN      = ctrl_q.mem_r_en;
    assign bus.MEM_W_EN      = ctrl_q.mem_w_en;
    assign bus.B             = ctrl_q.b;
    assign bus.S             = ctrl_q.s;
    assign bus.EXE_CMD       = ctrl_q.exe_cmd;
    assign bus.Val_Rn        = data_q.val_rn;
    assign bus.Val_Rm        = data_q.val_rm;
    assign bus.imm           = data_q.imm;
    assign bus.Shift_operand = data_q.shift_operand;
    assign bus.Signed_imm_24 = data_q.signed_imm_24;
    assign bus.Dest          = data_q.dest;
    assign bus.PC_out        = data_q.pc;

endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    id_stage_pipelined_if #(.DATA_W(32), .PC_W(32)) bus ();

    id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.Instruction = 32'hE0805005; bus.PC_in = 32'h40;
        tick(); tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL rst_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.EXE_CMD !== 4'h0) begin n_err++; $display("FAIL rst_cmd: got %0h want 0", bus.EXE_CMD); end
        n_vec++; if (bus.Val_Rm !== 32'h0) begin n_err++; $display("FAIL rst_valrm: got %0h want 0", bus.Val_Rm); end
        n_vec++; if (bus.PC_out !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %0h want 0", bus.PC_out); end
        n_vec++; if (bus.Dest !== 4'h0) begin n_err++; $display("FAIL rst_dest: got %0h want 0", bus.Dest); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.src1 !== 4'h0) begin n_err++; $display("FAIL add_src1: got %0h want 0", bus.src1); end
        n_vec++; if (bus.src2 !== 4'h5) begin n_err++; $display("FAIL add_src2: got %0h want 5", bus.src2); end
        n_vec++; if (bus.Two_src !== 1'b1) begin n_err++; $display("FAIL add_twosrc: got %0h want 1", bus.Two_src); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0h want 1", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b1) begin n_err++; $display("FAIL add_wb: got %0h want 1", bus.WB_EN); end
        n_vec++; if (bus.EXE_CMD !== 4'b0010) begin n_err++; $display("FAIL add_cmd: got %0h want 2", bus.EXE_CMD); end
        n_vec++; if (bus.Val_Rn !== 32'h0) begin n_err++; $display("FAIL add_valrn: got %0h want 0", bus.Val_Rn); end
        n_vec++; if (bus.Val_Rm !== 32'h5) begin n_err++; $display("FAIL add_valrm: got %0h want 5", bus.Val_Rm); end
        n_vec++; if (bus.Dest !== 4'h5) begin n_err++; $display("FAIL add_dest: got %0h want 5", bus.Dest); end
        n_vec++; if (bus.PC_out !== 32'h40) begin n_err++; $display("FAIL add_pc: got %0h want 40", bus.PC_out); end
    endtask

    task automatic test_bypass();
        bus.PC_in = 32'h44;
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd5; bus.Result_WB = 32'hDEAD;
        tick();
        n_vec++; if (bus.Val_Rm !== 32'hDEAD) begin n_err++; $display("FAIL byp_same: got %0h want dead", bus.Val_Rm); end
        n_vec++; if (bus.Val_Rn !== 32'h0) begin n_err++; $display("FAIL byp_rn: got %0h want 0", bus.Val_Rn); end
        bus.writeBackEn = 1'b0; bus.Result_WB = 32'h0;
        tick();
        n_vec++; if (bus.Val_Rm !== 32'hDEAD) begin n_err++; $display("FAIL byp_later: got %0h want dead", bus.Val_Rm); end
    endtask

    task automatic test_condition();
        bus.Instruction = 32'h00811002; bus.SR = 4'b0000;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL eq_fail_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL eq_fail_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.Dest !== 4'h1) begin n_err++; $display("FAIL eq_fail_dest: got %0h want 1", bus.Dest); end
        bus.SR = 4'b1000;
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL eq_pass_valid: got %0h want 1", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b1) begin n_err++; $display("FAIL eq_pass_wb: got %0h want 1", bus.WB_EN); end
        n_vec++; if (bus.Val_Rm !== 32'h2) begin n_err++; $display("FAIL eq_pass_valrm: got %0h want 2", bus.Val_Rm); end
        bus.Instruction = 32'hA0811002; bus.SR = 4'b0001;   // GE with N=1,V=0
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ge_fail: got %0h want 0", bus.out_valid); end
        bus.SR = 4'b0011;                                    // N=1,V=1
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ge_pass: got %0h want 1", bus.out_valid); end
        bus.Instruction = 32'hF0811002; bus.SR = 4'b1111;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL nv_fail: got %0h want 0", bus.out_valid); end
        bus.SR = 4'b0000;
    endtask

    task automatic test_memory();
        bus.Instruction = 32'hE5812000;
        #1;
        n_vec++; if (bus.src2 !== 4'h2) begin n_err++; $display("FAIL str_src2: got %0h want 2", bus.src2); end
        n_vec++; if (bus.Two_src !== 1'b1) begin n_err++; $display("FAIL str_twosrc: got %0h want 1", bus.Two_src); end
        tick();
        n_vec++; if (bus.MEM_W_EN !== 1'b1) begin n_err++; $display("FAIL str_memw: got %0h want 1", bus.MEM_W_EN); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL str_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.Val_Rm !== 32'h2) begin n_err++; $display("FAIL str_valrm: got %0h want 2", bus.Val_Rm); end
        bus.Instruction = 32'hE5912000;
        #1;
        n_vec++; if (bus.src2 !== 4'h0) begin n_err++; $display("FAIL ldr_src2: got %0h want 0", bus.src2); end
        tick();
        n_vec++; if (bus.MEM_R_EN !== 1'b1) begin n_err++; $display("FAIL ldr_memr: got %0h want 1", bus.MEM_R_EN); end
        n_vec++; if (bus.WB_EN !== 1'b1) begin n_err++; $display("FAIL ldr_wb: got %0h want 1", bus.WB_EN); end
        n_vec++; if (bus.S !== 1'b0) begin n_err++; $display("FAIL ldr_s: got %0h want 0", bus.S); end
        n_vec++; if (bus.MEM_W_EN !== 1'b0) begin n_err++; $display("FAIL ldr_memw: got %0h want 0", bus.MEM_W_EN); end
        n_vec++; if (bus.EXE_CMD !== 4'b0010) begin n_err++; $display("FAIL ldr_cmd: got %0h want 2", bus.EXE_CMD); end
    endtask

    task automatic test_data_proc();
        bus.Instruction = 32'hE3A01005;                      // MOV R1,#5
        #1;
        n_vec++; if (bus.Two_src !== 1'b0) begin n_err++; $display("FAIL mov_twosrc: got %0h want 0", bus.Two_src); end
        tick();
        n_vec++; if (bus.EXE_CMD !== 4'b0001) begin n_err++; $display("FAIL mov_cmd: got %0h want 1", bus.EXE_CMD); end
        n_vec++; if (bus.imm !== 1'b1) begin n_err++; $display("FAIL mov_imm: got %0h want 1", bus.imm); end
        n_vec++; if (bus.Shift_operand !== 12'h005) begin n_err++; $display("FAIL mov_shop: got %0h want 5", bus.Shift_operand); end
        bus.Instruction = 32'hE1510002;                      // CMP R1,R2 (S=1)
        tick();
        n_vec++; if (bus.EXE_CMD !== 4'b0100) begin n_err++; $display("FAIL cmp_cmd: got %0h want 4", bus.EXE_CMD); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL cmp_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.S !== 1'b1) begin n_err++; $display("FAIL cmp_s: got %0h want 1", bus.S); end
        bus.Instruction = 32'hE0610002;                      // opcode 0011: not decoded
        tick();
        n_vec++; if (bus.EXE_CMD !== 4'h0) begin n_err++; $display("FAIL undef_cmd: got %0h want 0", bus.EXE_CMD); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL undef_wb: got %0h want 0", bus.WB_EN); end
    endtask

    task automatic test_hazard_freeze();
        bus.Instruction = 32'hE0823004; bus.PC_in = 32'h60; bus.hazard = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL haz_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.EXE_CMD !== 4'h0) begin n_err++; $display("FAIL haz_cmd: got %0h want 0", bus.EXE_CMD); end
        n_vec++; if (bus.Dest !== 4'h3) begin n_err++; $display("FAIL haz_dest: got %0h want 3", bus.Dest); end
        n_vec++; if (bus.Val_Rn !== 32'h2) begin n_err++; $display("FAIL haz_valrn: got %0h want 2", bus.Val_Rn); end
        n_vec++; if (bus.Val_Rm !== 32'h4) begin n_err++; $display("FAIL haz_valrm: got %0h want 4", bus.Val_Rm); end
        bus.hazard = 1'b0; bus.freeze = 1'b1; bus.Instruction = 32'hE0805005; bus.PC_in = 32'h64;
        tick();
        n_vec++; if (bus.Dest !== 4'h3) begin n_err++; $display("FAIL frz_dest: got %0h want 3", bus.Dest); end
        n_vec++; if (bus.Val_Rm !== 32'h4) begin n_err++; $display("FAIL frz_valrm: got %0h want 4", bus.Val_Rm); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL frz_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.PC_out !== 32'h60) begin n_err++; $display("FAIL frz_pc: got %0h want 60", bus.PC_out); end
        bus.freeze = 1'b0;
        tick();
        // Freeze a valid ADD while a writeback to R9 happens underneath
        bus.freeze = 1'b1; bus.Instruction = 32'hE5912000;
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd9; bus.Result_WB = 32'h99;
        tick();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL frz2_valid: got %0h want 1", bus.out_valid); end
        n_vec++; if (bus.MEM_R_EN !== 1'b0) begin n_err++; $display("FAIL frz2_memr: got %0h want 0", bus.MEM_R_EN); end
        n_vec++; if (bus.Val_Rm !== 32'hDEAD) begin n_err++; $display("FAIL frz2_valrm: got %0h want dead", bus.Val_Rm); end
        bus.freeze = 1'b0; bus.writeBackEn = 1'b0; bus.Result_WB = 32'h0;
        bus.Instruction = 32'hE0809009;
        tick();
        n_vec++; if (bus.Val_Rm !== 32'h99) begin n_err++; $display("FAIL frz_wr_r9: got %0h want 99", bus.Val_Rm); end
    endtask

    task automatic test_priority();
        bus.Instruction = 32'hE0805005;
        tick();
        bus.freeze = 1'b1; bus.flush = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL flush_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.EXE_CMD !== 4'h0) begin n_err++; $display("FAIL flush_cmd: got %0h want 0", bus.EXE_CMD); end
        bus.freeze = 1'b0; bus.flush = 1'b0;
        bus.Instruction = 32'hEAFFFFFE; bus.PC_in = 32'h200;
        tick();
        n_vec++; if (bus.B !== 1'b1) begin n_err++; $display("FAIL br_b: got %0h want 1", bus.B); end
        n_vec++; if (bus.Signed_imm_24 !== 24'hFFFFFE) begin n_err++; $display("FAIL br_imm24: got %0h want fffffe", bus.Signed_imm_24); end
        n_vec++; if (bus.PC_out !== 32'h200) begin n_err++; $display("FAIL br_pc: got %0h want 200", bus.PC_out); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL br_wb: got %0h want 0", bus.WB_EN); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL br_valid: got %0h want 1", bus.out_valid); end
        bus.in_valid = 1'b0; bus.Instruction = 32'hE0805005;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL inval_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.WB_EN !== 1'b0) begin n_err++; $display("FAIL inval_wb: got %0h want 0", bus.WB_EN); end
        bus.in_valid = 1'b1;
    endtask

    task automatic test_midreset();
        bus.writeBackEn = 1'b1; bus.Dest_wb = 4'd7; bus.Result_WB = 32'h1234;
        tick();
        bus.writeBackEn = 1'b0; bus.Result_WB = 32'h0;
        bus.Instruction = 32'hE0807007; rst = 1'b0;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %0h want 0", bus.out_valid); end
        n_vec++; if (bus.Val_Rm !== 32'h0) begin n_err++; $display("FAIL mrst_valrm: got %0h want 0", bus.Val_Rm); end
        rst = 1'b1;
        tick();
        n_vec++; if (bus.Val_Rm !== 32'h7) begin n_err++; $display("FAIL mrst_reinit: got %0h want 7", bus.Val_Rm); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mrst_valid2: got %0h want 1", bus.out_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.Instruction = 32'h0; bus.PC_in = 32'h0;
        bus.Result_WB = 32'h0; bus.writeBackEn = 1'b0; bus.Dest_wb = 4'h0;
        bus.hazard = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0; bus.SR = 4'h0;
        test_reset();
        test_bypass();
        test_condition();
        test_memory();
        test_data_proc();
        test_hazard_freeze();
        test_priority();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register and register file. It takes a fetched ARM-subset instruction and produces registered control and operand fields for EXE. Over a plain decode stage it adds:
- an in_valid/out_valid qualifier;
- freeze (hold), hazard bubble and branch flush, with fixed priority;
- write-through bypass from WB to the register-file read ports;
- PC pass-through.

Parameters:
DATA_W, 32, width of register file entries, Result_WB, Val_Rn, Val_Rm.
NUM_REGS, 16, implemented registers, range 2..16; instruction register fields stay 4 bits.
PC_W, 32, width of PC_in/PC_out.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
in_valid  input  1  Instruction/PC_in valid
Instruction  input  32  instruction from IF/ID
PC_in  input  PC_W  PC of Instruction
Result_WB  input  DATA_W  writeback data
writeBackEn  input  1  writeback enable
Dest_wb  input  4  writeback register
hazard  input  1  insert bubble this cycle
freeze  input  1  hold ID/EX register contents
flush  input  1  squash (taken branch)
SR  input  4  {Z,C,V,N} = SR[3:0]
src1  output  4  Instruction[19:16], combinational
src2  output  4  MEM_W decode ? Instruction[15:12] : Instruction[3:0], combinational
Two_src  output  1  ~Instruction[25] | store decode, combinational
out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S  output  1 each  registered controls
EXE_CMD  output  4  registered
Val_Rn, Val_Rm  output  DATA_W  registered operands
imm  output  1  registered Instruction[25]
Shift_operand  output  12  registered Instruction[11:0]
Signed_imm_24  output  24  registered Instruction[23:0]
Dest  output  4  registered Instruction[15:12]
PC_out  output  PC_W  registered PC_in

Behaviour:
Fields:
- cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0].

Decode by mode:
- Mode 00, data processing, opcode -> EXE_CMD:
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101.
  - AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
  - WB_EN = 1 except for CMP and TST. S = Instruction[20].
  - Any other opcode: all controls 0.
- Mode 01, memory:
  - Instruction[20]=1 is LDR: EXE_CMD 0010, MEM_R_EN=1, WB_EN=1.
  - Instruction[20]=0 is STR: EXE_CMD 0010, MEM_W_EN=1.
  - S=0 for both.
- Mode 10: B=1, everything else 0.
- Mode 11: all controls 0.

Condition check (standard ARM):
- Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL (1110).
- 1111 is treated as fail.

Register file:
- NUM_REGS x DATA_W. Reset loads reg[i] = i.
- Written at the clock edge when writeBackEn=1 and Dest_wb < NUM_REGS.
- Writes occur regardless of freeze/hazard/flush.
- Read ports are combinational with bypass: if writeBackEn=1 and Dest_wb equals the read address, the port returns Result_WB.
- Addresses >= NUM_REGS read 0.

Control-kill term: `kill = ~in_valid | hazard | ~cond_pass`.

ID/EX register update, per edge, in priority order:
1. rst=0: all outputs 0 (PC_out 0, Val_* 0).
2. flush=1: out_valid and all control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD) cleared. Data fields don't-care; implementation loads them normally.
3. freeze=1: every registered output holds.
4. Otherwise: data fields load from the current instruction. Control bits and out_valid load their decoded values ANDed with ~kill (out_valid = ~kill).

Timing and boundaries:
- Latency: one cycle from inputs to registered outputs.
- src1/src2/Two_src are valid in the same cycle and are not gated by kill.
- Flush overrides freeze in the same cycle. Reset overrides all.
- Reset asserted mid-stream: outputs are 0 on the next edge; the register file reinitialises.
- Simultaneous write and read of the same register: the bypassed Result_WB is captured. Without the bypass, the old value would be captured.

Test Plan:
1. Reset: rst=0 for 2 edges -> all outputs 0. After release, read of R5 via Instruction 0xE0805005 (ADD R5,R0,R5), no writeback -> Val_Rn=0, Val_Rm=5, EXE_CMD=0010, WB_EN=1, Dest=5, out_valid=1.
2. Bypass: same ADD with writeBackEn=1, Dest_wb=5, Result_WB=0xDEAD in that cycle -> Val_Rm=0xDEAD next edge; a later read of R5 also returns 0xDEAD.
3. Condition: SR=4'b0000, Instruction 0x00811002 (ADDEQ) -> out_valid=0, WB_EN=0. Same instruction with SR=4'b1000 -> out_valid=1, WB_EN=1.
4. Memory: STR 0xE5812000 -> src2=2, Two_src=1, MEM_W_EN=1, WB_EN=0. LDR 0xE5912000 -> MEM_R_EN=1, WB_EN=1, src2=0.
5. Hazard, then freeze: hazard=1 with a valid ADD -> bubble (out_valid=0, EXE_CMD=0) but Dest/Val updated. Next cycle freeze=1 with a new instruction -> all outputs unchanged.
6. Priority: freeze=1 and flush=1 together -> out_valid=0 and controls 0. Branch 0xEAFFFFFE -> B=1, Signed_imm_24=0xFFFFFE, PC_out=PC_in.
